// File: rtl/majority_pkg.sv
// majority_pkg: filter state type and width helpers shared by the majority voter files.
package majority_pkg;

    typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_e;

    function automatic int ones_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int cnt_w(input int persist);
        return $clog2(persist + 1);
    endfunction

endpackage

// File: rtl/majority_voter_popcount.sv
// popcount: purely combinational count of set bits in an N-bit vector.
module popcount
    import majority_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]          bits_i,
    output logic [ones_w(N)-1:0]  count_o
);

    localparam int OW = ones_w(N);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) count_o = count_o + OW'(bits_i[i]);
    end

endmodule

// File: rtl/majority_voter.sv
// majority_voter: N-input majority vote with a persistence filter that only lets
// the output flip after PERSIST consecutive valid samples disagree with it.
module majority_voter
    import majority_pkg::*;
#(
    parameter int N       = 5,
    parameter int PERSIST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N-1:0]         in_bits,
    output logic                 out_maj,
    output logic                 out_valid,
    output logic [ones_w(N)-1:0] ones_count,
    output logic                 disagree,
    output logic                 pending,
    output logic                 switch_pulse
);

    localparam int OW = ones_w(N);
    localparam int CW = cnt_w(PERSIST);

    if (N < 3 || N > 15 || (N % 2) == 0) begin : g_bad_n
        $error("majority_voter: N must be odd and within 3..15");
    end
    if (PERSIST < 1 || PERSIST > 255) begin : g_bad_persist
        $error("majority_voter: PERSIST must be within 1..255");
    end

    logic [OW-1:0] pc;
    logic          raw;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          maj_q, maj_d, sw_d;

    popcount #(.N(N)) u_popcount (
        .bits_i  (in_bits),
        .count_o (pc)
    );

    assign raw     = pc >= OW'((N + 1) / 2);
    assign cnt_inc = cnt_q + CW'(1);

    // cnt is 0 in STABLE, so one disagreeing sample there gives cnt_inc==1,
    // which also covers the immediate flip when PERSIST==1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        maj_d   = maj_q;
        sw_d    = 1'b0;
        if (in_valid) begin
            state_d = (raw == maj_q || cnt_inc == CW'(PERSIST)) ? STABLE : PENDING;
            cnt_d   = (raw == maj_q || cnt_inc == CW'(PERSIST)) ? '0 : cnt_inc;
            sw_d    = raw != maj_q && cnt_inc == CW'(PERSIST);
            maj_d   = sw_d ? raw : maj_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= STABLE;
            cnt_q        <= '0;
            maj_q        <= 1'b0;
            out_valid    <= 1'b0;
            ones_count   <= '0;
            disagree     <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            maj_q        <= maj_d;
            out_valid    <= in_valid;
            switch_pulse <= sw_d;
            if (in_valid) begin
                ones_count <= pc;
                disagree   <= pc != '0 && pc != OW'(N);
            end
        end
    end

    assign out_maj = maj_q;
    assign pending = state_q == PENDING;

endmodule

// File: tb/tb_majority_voter.sv
// tb_majority_voter: directed vectors against an N=3/PERSIST=1 and an N=5/PERSIST=3 voter.
module tb_majority_voter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       v3 = 1'b0, v5 = 1'b0;
    logic [2:0] b3 = '0;
    logic [4:0] b5 = '0;
    logic       maj3, ov3, dis3, pend3, sw3;
    logic [1:0] oc3;
    logic       maj5, ov5, dis5, pend5, sw5;
    logic [2:0] oc5;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    majority_voter #(.N(3), .PERSIST(1)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_bits(b3),
        .out_maj(maj3), .out_valid(ov3), .ones_count(oc3),
        .disagree(dis3), .pending(pend3), .switch_pulse(sw3)
    );

    majority_voter #(.N(5), .PERSIST(3)) u_d5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_bits(b5),
        .out_maj(maj5), .out_valid(ov5), .ones_count(oc5),
        .disagree(dis5), .pending(pend5), .switch_pulse(sw5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step5(input logic v, input logic [4:0] b, input logic r = 1'b0);
        @(negedge clk);
        rst = r;
        v5  = v;
        b5  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic v, input logic [2:0] b);
        @(negedge clk);
        rst = 1'b0;
        v3  = v;
        b3  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check5_zero(input string tag);
        check({tag, ".maj"}, 32'(maj5), 0);
        check({tag, ".ov"}, 32'(ov5), 0);
        check({tag, ".oc"}, 32'(oc5), 0);
        check({tag, ".dis"}, 32'(dis5), 0);
        check({tag, ".pend"}, 32'(pend5), 0);
        check({tag, ".sw"}, 32'(sw5), 0);
    endtask

    initial begin
        logic [7:0] maj_tbl;
        maj_tbl = 8'b1110_1000;

        step5(1'b1, 5'b11111, 1'b1);
        check5_zero("reset");
        check("reset.maj3", 32'(maj3), 0);
        check("reset.pend3", 32'(pend3), 0);

        // N=3, PERSIST=1: output tracks raw majority one cycle later
        for (int i = 0; i < 8; i++) begin
            step3(1'b1, 3'(i));
            check($sformatf("p1.maj[%0d]", i), 32'(maj3), 32'(maj_tbl[i]));
            check($sformatf("p1.ov[%0d]", i), 32'(ov3), 1);
            check($sformatf("p1.pend[%0d]", i), 32'(pend3), 0);
        end
        check("p1.sw_on_111", 32'(sw3), 0);
        step3(1'b0, 3'b000);
        check("p1.gap_maj", 32'(maj3), 1);
        check("p1.gap_ov", 32'(ov3), 0);

        // persistence run of three 00111
        step5(1'b0, 5'b0, 1'b1);
        step5(1'b1, 5'b00111);
        check("run.e1.pend", 32'(pend5), 1);
        check("run.e1.maj", 32'(maj5), 0);
        check("run.e1.sw", 32'(sw5), 0);
        check("run.e1.oc", 32'(oc5), 3);
        check("run.e1.dis", 32'(dis5), 1);
        check("run.e1.ov", 32'(ov5), 1);
        step5(1'b1, 5'b00111);
        check("run.e2.pend", 32'(pend5), 1);
        check("run.e2.maj", 32'(maj5), 0);
        check("run.e2.sw", 32'(sw5), 0);
        step5(1'b1, 5'b00111);
        check("run.e3.maj", 32'(maj5), 1);
        check("run.e3.sw", 32'(sw5), 1);
        check("run.e3.pend", 32'(pend5), 0);
        check("run.e3.ov", 32'(ov5), 1);
        step5(1'b0, 5'b00111);
        check("run.e4.sw", 32'(sw5), 0);
        check("run.e4.maj", 32'(maj5), 1);
        check("run.e4.ov", 32'(ov5), 0);

        // interrupted run returns to STABLE without switching
        step5(1'b0, 5'b0, 1'b1);
        step5(1'b1, 5'b11100);
        check("abort.e1.pend", 32'(pend5), 1);
        check("abort.e1.sw", 32'(sw5), 0);
        step5(1'b1, 5'b11100);
        check("abort.e2.pend", 32'(pend5), 1);
        check("abort.e2.sw", 32'(sw5), 0);
        step5(1'b1, 5'b00000);
        check("abort.e3.pend", 32'(pend5), 0);
        check("abort.e3.maj", 32'(maj5), 0);
        check("abort.e3.sw", 32'(sw5), 0);
        step5(1'b1, 5'b11111);
        step5(1'b1, 5'b11111);
        check("abort.fresh2.maj", 32'(maj5), 0);

        // gaps hold the filter
        step5(1'b0, 5'b0, 1'b1);
        step5(1'b1, 5'b11111);
        check("gap.e1.pend", 32'(pend5), 1);
        for (int i = 0; i < 5; i++) begin
            step5(1'b0, 5'b00000);
            check($sformatf("gap.ov[%0d]", i), 32'(ov5), 0);
            check($sformatf("gap.pend[%0d]", i), 32'(pend5), 1);
            check($sformatf("gap.maj[%0d]", i), 32'(maj5), 0);
        end
        step5(1'b1, 5'b11111);
        check("gap.e2.maj", 32'(maj5), 0);
        step5(1'b1, 5'b11111);
        check("gap.e3.maj", 32'(maj5), 1);
        check("gap.e3.sw", 32'(sw5), 1);
        check("gap.e3.oc", 32'(oc5), 5);

        // reset mid-run discards the partial count and the concurrent sample
        step5(1'b0, 5'b0, 1'b1);
        step5(1'b1, 5'b11111);
        step5(1'b1, 5'b11111);
        step5(1'b1, 5'b11111, 1'b1);
        check5_zero("midrst");
        step5(1'b1, 5'b11111);
        check("midrst.e1.maj", 32'(maj5), 0);
        step5(1'b1, 5'b11111);
        check("midrst.e2.maj", 32'(maj5), 0);
        step5(1'b1, 5'b11111);
        check("midrst.e3.maj", 32'(maj5), 1);

        // unanimous samples never flag disagreement
        step5(1'b1, 5'b00000);
        check("unan0.oc", 32'(oc5), 0);
        check("unan0.dis", 32'(dis5), 0);
        step5(1'b1, 5'b11111);
        check("unan1.oc", 32'(oc5), 5);
        check("unan1.dis", 32'(dis5), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/majority_voter.md
MAJORITY_VOTER -- requirements
Module: majority_voter

Interface
REQ-001 The block SHALL expose parameter N, default 5, meaning the number of voter inputs; legal values are odd, 3..15.
REQ-002 The block SHALL expose parameter PERSIST, default 4, meaning the number of consecutive valid disagreeing samples required before the output switches; legal range is 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_bits is sampled this cycle.
REQ-006 The block SHALL have port in_bits, input, N bits: one vote per bit.
REQ-007 The block SHALL have port out_maj, output, 1 bit: the filtered majority decision.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking the registered result of a sample.
REQ-009 The block SHALL have port ones_count, output, clog2(N+1) bits: the popcount of the last valid sample.
REQ-010 The block SHALL have port disagree, output, 1 bit: the last valid sample was not unanimous.
REQ-011 The block SHALL have port pending, output, 1 bit: the filter holds a candidate that differs from out_maj.
REQ-012 The block SHALL have port switch_pulse, output, 1 bit: out_maj changed at this edge; high for one cycle.

Function
REQ-013 The raw majority SHALL be 1 iff popcount(in_bits) >= (N+1)/2, evaluated combinationally on the current sample.
REQ-014 On an edge with in_valid=1, the block SHALL register ones_count and disagree (popcount != 0 and != N), and SHALL set out_valid=1 for the following cycle; latency is 1 cycle.
REQ-015 On an edge with in_valid=0, the block SHALL set out_valid=0 and hold all other state, so gaps neither advance nor clear the filter.
REQ-016 The filter SHALL be an FSM with states STABLE and PENDING, plus a saturating counter cnt of width clog2(PERSIST+1).
REQ-017 In STABLE, a valid sample with raw==out_maj SHALL cause no change.
REQ-018 In STABLE, a valid sample with raw!=out_maj SHALL set cnt=1 and move to PENDING; if PERSIST==1, it SHALL instead flip out_maj immediately and remain in STABLE.
REQ-019 In PENDING, a valid sample with raw!=out_maj SHALL increment cnt; when cnt reaches PERSIST, the block SHALL flip out_maj, pulse switch_pulse, clear cnt, and go to STABLE, all at that same edge.
REQ-020 In PENDING, a valid sample with raw==out_maj SHALL clear cnt and return to STABLE with no switch.
REQ-021 pending SHALL equal (state==PENDING), registered.
REQ-022 The change in out_maj SHALL be visible in the same cycle as the out_valid pulse of the sample that completed the persistence run.
REQ-023 With PERSIST=1, out_maj SHALL equal the raw majority of the last valid sample, delayed 1 cycle.

Reset
REQ-024 When rst=1 at an edge, the block SHALL clear out_maj, out_valid, ones_count, disagree, pending, switch_pulse, and cnt to 0, and set state to STABLE.
REQ-025 rst SHALL take priority over in_valid in the same cycle, and the sample presented in that cycle SHALL be discarded.
REQ-026 A reset asserted during PENDING SHALL discard the partial run, so that a fresh PERSIST valid samples are needed afterwards.

Structure
REQ-027 The FSM state enum (STABLE, PENDING) and the width helper functions SHALL reside in the shared package majority_pkg.
REQ-028 The popcount SHALL be a sub-module, popcount, parametrised by width N and purely combinational.
REQ-029 Parameter legality (N odd, range checks) SHALL be enforced by elaboration-time assertions.

Verification
REQ-030 Set N=3, PERSIST=1; apply 000..111 with in_valid=1, one per cycle. Required: one cycle later, out_maj=1 exactly for 011, 101, 110 and 111.
REQ-031 Set N=5, PERSIST=3; after reset, apply 3 valid samples of 00111. Required: out_maj rises at the 3rd edge with switch_pulse=1 for one cycle, ones_count=3, disagree=1, and pending=1 after the 1st and 2nd edges.
REQ-032 Set N=5, PERSIST=3; apply 11100, 11100, then 00000. Required: out_maj stays 0, pending returns to 0, and switch_pulse never asserts.
REQ-033 Set N=5, PERSIST=3; apply valid 11111, then 5 cycles with in_valid=0, then 2 valid 11111. Required: out_maj flips on the 3rd valid sample, and out_valid=0 throughout the gap.
REQ-034 Set N=5, PERSIST=3; apply 2 valid 11111, then assert rst for 1 cycle. Required: all outputs are 0, and 3 further valid 11111 samples are needed to set out_maj=1.
REQ-035 Apply 00000 and then 11111 as valid samples. Required: disagree=0 for both, with ones_count=0 and then ones_count=5.
